// File: rtl/sgd_mul_lanes.sv
// Four-lane time-multiplexed Q(LENGTH-FRAC).FRAC multiply datapath for the SGD engine.
// Sweeps 15 feature slots through four Baugh-Wooley multipliers in four cycles.
module sgd_mul_lanes #(
   parameter int unsigned LENGTH = 16,
   parameter int unsigned FRAC   = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic                   mode,
   input  logic [15*LENGTH-1:0]   x_bus,
   input  logic [15*LENGTH-1:0]   w_bus,
   input  logic [LENGTH-1:0]      error,
   input  logic [3:0]             learn_rate,
   output logic [4*LENGTH-1:0]    p_bus,
   output logic [1:0]             sel,
   output logic                   valid,
   output logic                   busy
);

   localparam int unsigned NUM_FEAT  = 15;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned PW        = 2 * LENGTH;

   typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              load;
   logic [LENGTH-1:0] err_scaled;
   logic [4*LENGTH-1:0] prod_bus;

   // Signed array multiply: complemented sign cross-terms plus the two
   // constant correction bits make an unsigned row sum equal the signed product.
   function automatic logic [LENGTH-1:0] bw_mul(input logic [LENGTH-1:0] a,
                                                input logic [LENGTH-1:0] b);
      logic [PW-1:0] acc;
      logic [PW-1:0] row;
      logic          pp;
      acc             = '0;
      acc[LENGTH]     = 1'b1;
      acc[PW-1]       = 1'b1;
      for (int i = 0; i < int'(LENGTH); i++) begin
         row = '0;
         for (int j = 0; j < int'(LENGTH); j++) begin
            pp = a[i] & b[j];
            if ((i == int'(LENGTH) - 1) != (j == int'(LENGTH) - 1))
               pp = ~pp;
            row[i + j] = pp;
         end
         acc = acc + row;
      end
      return acc[FRAC+LENGTH-1:FRAC];
   endfunction

   assign err_scaled = LENGTH'($signed(error) >>> learn_rate);

   // Per-lane operand muxes and multiplier; slot 16 (lane 4, cycle 3) is dead.
   for (genvar k = 0; k < int'(NUM_LANES); k++) begin : g_lane
      logic [LENGTH-1:0] x_opt [NUM_LANES];
      logic [LENGTH-1:0] w_opt [NUM_LANES];
      logic [NUM_LANES-1:0] live_v;
      logic [LENGTH-1:0] a_op;
      logic [LENGTH-1:0] b_op;

      for (genvar c = 0; c < int'(NUM_LANES); c++) begin : g_slot
         if (4 * k + c < int'(NUM_FEAT)) begin : g_live
            assign x_opt[c]  = x_bus[LENGTH*(NUM_FEAT-1-4*k-c) +: LENGTH];
            assign w_opt[c]  = w_bus[LENGTH*(NUM_FEAT-1-4*k-c) +: LENGTH];
            assign live_v[c] = 1'b1;
         end else begin : g_dead
            assign x_opt[c]  = '0;
            assign w_opt[c]  = '0;
            assign live_v[c] = 1'b0;
         end
      end

      always_comb begin
         a_op = '0;
         b_op = '0;
         if (live_v[cnt_q]) begin
            a_op = x_opt[cnt_q];
            b_op = mode_q ? err_scaled : w_opt[cnt_q];
         end
      end

      assign prod_bus[LENGTH*(NUM_LANES-1-k) +: LENGTH] = bw_mul(a_op, b_op);
   end

   // Sweep control state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state: start accepted when idle or on the last cycle of a sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = 2'd0;
               mode_d  = mode;
            end
         end
         S_RUN: begin
            load  = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               cnt_d = 2'd0;
               if (start)
                  mode_d = mode;
               else
                  state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // Registered outputs; products and sel hold after the sweep ends.
   always_ff @(posedge CLK) begin
      if (RST) begin
         p_bus <= '0;
         sel   <= 2'd0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         valid <= load;
         busy  <= (state_d == S_RUN);
         if (load) begin
            p_bus <= prod_bus;
            sel   <= cnt_q;
         end
      end
   end

endmodule

// File: tb/tb_sgd_mul_lanes.sv
// Scoreboard bench for sgd_mul_lanes: expected lane products are queued at
// sweep launch and compared as valid results emerge.
module tb_sgd_mul_lanes;

   localparam int unsigned LENGTH = 16;
   localparam int unsigned FRAC   = 8;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic                 start;
   logic                 mode;
   logic [15*LENGTH-1:0] x_bus;
   logic [15*LENGTH-1:0] w_bus;
   logic [LENGTH-1:0]    error;
   logic [3:0]           learn_rate;
   logic [4*LENGTH-1:0]  p_bus;
   logic [1:0]           sel;
   logic                 valid;
   logic                 busy;

   typedef struct {
      logic [1:0]  sel;
      logic [63:0] p;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] xv [1:15];
   logic [15:0] wv [1:15];
   logic [15:0] err_v;
   logic [3:0]  lr_v;
   int          total = 0;
   int          bad = 0;
   int          run = 0;
   int          last_run = 0;

   sgd_mul_lanes #(.LENGTH(LENGTH), .FRAC(FRAC)) dut (
      .CLK(CLK), .RST(RST), .start(start), .mode(mode),
      .x_bus(x_bus), .w_bus(w_bus), .error(error), .learn_rate(learn_rate),
      .p_bus(p_bus), .sel(sel), .valid(valid), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic randomize_data();
      for (int f = 1; f <= 15; f++) begin
         xv[f] = 16'($urandom);
         wv[f] = 16'($urandom);
      end
      err_v = 16'($urandom);
      lr_v  = 4'($urandom);
   endtask

   task automatic apply_inputs();
      for (int f = 1; f <= 15; f++) begin
         x_bus[16*(15-f) +: 16] = xv[f];
         w_bus[16*(15-f) +: 16] = wv[f];
      end
      error      = err_v;
      learn_rate = lr_v;
   endtask

   // Reference: plain integer multiply, then take the Q8.8 window.
   task automatic push_sweep(input logic m);
      exp_t               e;
      logic signed [15:0] es;
      logic signed [15:0] a;
      logic signed [15:0] b;
      int                 prod;
      int                 f;
      es = $signed(err_v) >>> lr_v;
      for (int c = 0; c < 4; c++) begin
         e.sel = 2'(c);
         e.p   = '0;
         for (int k = 1; k <= 4; k++) begin
            f = 4*(k-1) + c + 1;
            if (f == 16) begin
               prod = 0;
            end else begin
               a    = $signed(xv[f]);
               b    = m ? es : $signed(wv[f]);
               prod = int'(a) * int'(b);
            end
            e.p[16*(4-k) +: 16] = prod[23:8];
         end
         sbq.push_back(e);
      end
   endtask

   task automatic launch(input logic m);
      mode  = m;
      start = 1'b1;
      push_sweep(m);
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(negedge CLK);
      check_val("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_drain(input int exp_run);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(posedge CLK);
         n++;
      end
      check_val("drain", 64'(sbq.size()), 64'd0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_val("run_len", 64'(last_run), 64'(exp_run));
      check_val("idle_valid", 64'(valid), 64'd0);
      check_val("idle_busy", 64'(busy), 64'd0);
   endtask

   // Monitor: every valid cycle must match the head of the scoreboard.
   always @(negedge CLK) begin
      exp_t e;
      if (valid === 1'b1) begin
         run++;
         if (sbq.size() == 0) begin
            check_val("extra_valid", 64'd1, 64'd0);
         end else begin
            e = sbq.pop_front();
            check_val("sel", 64'(sel), 64'(e.sel));
            check_val("p_bus", p_bus, e.p);
         end
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      for (int f = 1; f <= 15; f++) begin
         xv[f] = '0;
         wv[f] = '0;
      end
      err_v = '0;
      lr_v  = '0;
      apply_inputs();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check_val("idle_outputs", {p_bus, sel, valid, busy}, '0);
      end

      // Prediction pass with known lanes 1 and 2
      @(posedge CLK); #1;
      randomize_data();
      xv[1] = 16'h0100; wv[1] = 16'h0200;
      xv[5] = 16'hFE80; wv[5] = 16'h0200;
      apply_inputs();
      launch(1'b0);
      wait_drain(4);

      // Update pass, positive error
      @(posedge CLK); #1;
      randomize_data();
      err_v = 16'h0400; lr_v = 4'd2;
      xv[1] = 16'h0300; xv[13] = 16'h1000;
      apply_inputs();
      launch(1'b1);
      wait_drain(4);

      // Update pass, negative error
      @(posedge CLK); #1;
      randomize_data();
      err_v = 16'hFF00; lr_v = 4'd4;
      xv[2] = 16'h1000;
      apply_inputs();
      launch(1'b1);
      wait_drain(4);

      // Wrap on slot 15 and dead slot 16
      @(posedge CLK); #1;
      randomize_data();
      xv[15] = 16'h8000; wv[15] = 16'h8000;
      apply_inputs();
      launch(1'b0);
      wait_drain(4);

      // Start pulsed at cnt=1 must be ignored
      @(posedge CLK); #1;
      randomize_data();
      apply_inputs();
      launch(1'b0);
      @(posedge CLK); #1;
      start = 1'b1;
      mode  = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      wait_drain(4);

      // Back-to-back sweeps: start at cnt=3, mode switches for the second
      @(posedge CLK); #1;
      randomize_data();
      apply_inputs();
      launch(1'b0);
      repeat (3) @(posedge CLK);
      #1;
      mode  = 1'b1;
      start = 1'b1;
      push_sweep(1'b1);
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      check_val("busy_chain", 64'(busy), 64'd1);
      wait_drain(8);

      // Reset during cnt=2 abandons the sweep
      @(posedge CLK); #1;
      randomize_data();
      apply_inputs();
      launch(1'b0);
      @(posedge CLK);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      sbq.delete();
      @(negedge CLK);
      check_val("rst_valid", 64'(valid), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_p_bus", p_bus, 64'd0);
      check_val("rst_sel", 64'(sel), 64'd0);
      repeat (6) @(negedge CLK);
      check_val("post_rst_valid", 64'(valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
